lbc_serial_encoder: RTL and testbench
=====================================

// Module: lbc_serial_encoder
// PURPOSE
//  Systematic (6,3) linear block encoder. Sits directly downstream of the generator-matrix stage.
//  Captures generator rows g1..g3 into a local G register.
//  Accepts 3-bit message words over a valid/ready handshake and forms codeword c = XOR of G rows selected by msg bits.
//  Serialises each 6-bit codeword MSB-first onto a valid/ready bit stream, with a one-deep pending buffer.
// PARAMETERS
//  CW_W    6  codeword width; only 6 supported.
//  MSG_W   3  message width; only 3 supported.
//  RST_G1  6'b000001  G row 1 after reset (identity, zero parity).
//  RST_G2  6'b000010  G row 2 after reset.
//  RST_G3  6'b000100  G row 3 after reset.
// PORTS
//  clk        in   1  rising-edge clock, single domain
//  rst        in   1  synchronous, active-high reset
//  en         in   1  block enable; low = freeze
//  g1,g2,g3   in   6  generator rows from upstream stage; bits[2:0] form the identity part
//  g_load     in   1  capture g1..g3 into G register this cycle
//  msg        in   3  message word; msg[0] selects g1, msg[1] g2, msg[2] g3
//  msg_valid  in   1  msg is valid
//  msg_ready  out  1  encoder can accept msg
//  ser_out    out  1  current codeword bit (shifter bit 5)
//  ser_valid  out  1  ser_out is valid
//  ser_ready  in   1  downstream takes ser_out
//  sof        out  1  high while ser_out is bit 5 of a codeword
//  eof        out  1  high while ser_out is bit 0 of a codeword
//  cw_out     out  6  parallel copy of the codeword being shifted
// BEHAVIOUR
//  Reset: G = RST_G1..3, state IDLE, cnt=0, pend_valid=0, shifter=0, cw_out=0.
//  Reset outputs: msg_ready=0, ser_valid=0, ser_out=0, sof=0, eof=0.
//  Reset mid-frame discards the shifter and pending word; no bits are emitted after reset.
//  G register: loads on rising clk when g_load=1, regardless of en or state.
//  A msg accepted in the same cycle as g_load is encoded with the OLD G.
//  Encode: cw = ({6{msg[0]}}&G1) ^ ({6{msg[1]}}&G2) ^ ({6{msg[2]}}&G3).
//  Encode is computed at accept. The frame keeps that value even if G changes mid-frame.
//  msg_ready = en & ~rst_q & ~pend_valid. Accept = msg_valid & msg_ready.
//  FSM states:
//   IDLE: ser_valid=0. On accept: shifter=cw, cw_out=cw, cnt=0, go to SHIFT.
//         ser_valid=1 in the next cycle, so accept-to-first-bit latency is 1 clk.
//   SHIFT: ser_valid=en; sof=(cnt==0); eof=(cnt==5).
//          Transfer = ser_valid & ser_ready.
//          On transfer with cnt<5: shift left by 1, cnt++.
//   SHIFT, last transfer (cnt==5):
//          - pend_valid=1: load pend_cw into shifter, pend_valid=0, cnt=0, stay in SHIFT.
//          - else, accept in the same cycle: load that cw directly, stay in SHIFT.
//          - else: go to IDLE.
//          No gap cycle between back-to-back frames.
//   SHIFT, accept other than at the last transfer: store cw in pend_cw, pend_valid=1.
//   Last transfer with pend_valid=1: the pending word is unloaded and msg_ready=0.
//          The buffer frees next cycle; no same-cycle refill.
//  ser_ready low: hold ser_out, cnt and shifter; ser_valid stays high (no retraction).
//  en low: no accept, ser_valid=0, no shift. All state, G and pending are held.
//          Resumes exactly where frozen when en returns high.
//  cw_out updates only when a new codeword enters the shifter.
// TESTING
//  1. rst 3 clks; load G1=110001, G2=011010, G3=101100; msg=011 with ser_ready=1
//     -> ser_valid at accept+1; bits 1,0,1,0,1,1; sof on bit 1, eof on bit 6; cw_out=101011.
//  2. msgs 111, 000, 100 back-to-back with ser_ready=1
//     -> 000111, 000000, 101100 with no idle cycle between frames; msg_ready low while pending is full.
//  3. After reset with no g_load, msg=101 -> cw 000101 (identity G).
//  4. ser_ready toggled 1/0 every clk during 011 -> same 6 bits, each held while ser_ready=0.
//  5. en=0 for 4 clks after bit 3 -> ser_valid=0, no accept; remaining 3 bits follow on en=1.
//  6. rst mid-frame after bit 2 with pending valid -> ser_valid=0 next clk; pending dropped; G=identity.

Source files
------------

// File: rtl/lbc_serial_encoder.sv
// Systematic (6,3) linear block encoder with a one-deep pending buffer and an
// MSB-first valid/ready bit-serial output.
module lbc_serial_encoder #(
  parameter int unsigned        CwW   = 6,
  parameter int unsigned        MsgW  = 3,
  parameter logic [CwW-1:0]     RstG1 = 6'b000001,
  parameter logic [CwW-1:0]     RstG2 = 6'b000010,
  parameter logic [CwW-1:0]     RstG3 = 6'b000100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [CwW-1:0]  g1_i,
  input  logic [CwW-1:0]  g2_i,
  input  logic [CwW-1:0]  g3_i,
  input  logic            g_load_i,
  input  logic [MsgW-1:0] msg_i,
  input  logic            msg_valid_i,
  output logic            msg_ready_o,
  output logic            ser_out_o,
  output logic            ser_valid_o,
  input  logic            ser_ready_i,
  output logic            sof_o,
  output logic            eof_o,
  output logic [CwW-1:0]  cw_out_o
);

  localparam logic [2:0] LastIdx = 3'(CwW - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [CwW-1:0] shift_q, shift_d;
  logic [CwW-1:0] cw_q, cw_d;
  logic [CwW-1:0] pend_cw_q, pend_cw_d;
  logic           pend_valid_q, pend_valid_d;
  logic [CwW-1:0] g1_q, g2_q, g3_q;
  logic           rst_q;

  logic [CwW-1:0] cw_enc;
  logic           accept, xfer, last_xfer;

  always_comb begin
    cw_enc = ({CwW{msg_i[0]}} & g1_q) ^ ({CwW{msg_i[1]}} & g2_q) ^ ({CwW{msg_i[2]}} & g3_q);

    // rst_q keeps the input closed for one cycle after reset releases
    msg_ready_o = en_i & ~rst_q & ~pend_valid_q;
    accept      = msg_valid_i & msg_ready_o;
    ser_valid_o = (state_q == StShift) & en_i;
    xfer        = ser_valid_o & ser_ready_i;
    last_xfer   = xfer & (cnt_q == LastIdx);
    ser_out_o   = shift_q[CwW-1];
    sof_o       = (state_q == StShift) & (cnt_q == 3'd0);
    eof_o       = (state_q == StShift) & (cnt_q == LastIdx);
    cw_out_o    = cw_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    cw_d         = cw_q;
    pend_cw_d    = pend_cw_q;
    pend_valid_d = pend_valid_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = cw_enc;
          cw_d    = cw_enc;
          cnt_d   = 3'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (xfer && !last_xfer) begin
          shift_d = {shift_q[CwW-2:0], 1'b0};
          cnt_d   = cnt_q + 3'd1;
        end else if (last_xfer) begin
          cnt_d = 3'd0;
          if (pend_valid_q) begin
            shift_d      = pend_cw_q;
            cw_d         = pend_cw_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            shift_d = cw_enc;
            cw_d    = cw_enc;
          end else begin
            state_d = StIdle;
          end
        end
        // An accept at the last transfer goes straight to the shifter instead
        if (accept && !last_xfer) begin
          pend_cw_d    = cw_enc;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      shift_q      <= '0;
      cw_q         <= '0;
      pend_cw_q    <= '0;
      pend_valid_q <= 1'b0;
      g1_q         <= RstG1;
      g2_q         <= RstG2;
      g3_q         <= RstG3;
      rst_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      cw_q         <= cw_d;
      pend_cw_q    <= pend_cw_d;
      pend_valid_q <= pend_valid_d;
      rst_q        <= 1'b0;
      if (g_load_i) begin
        g1_q <= g1_i;
        g2_q <= g2_i;
        g3_q <= g3_i;
      end
    end
  end

endmodule

// File: tb/tb_lbc_serial_encoder.sv
// Bench for lbc_serial_encoder: directed scenarios plus random traffic, every
// cycle checked against a frame-queue model of the encoder.
module tb_lbc_serial_encoder;

  logic       clk = 1'b0;
  logic       rst, en, g_load, msg_valid, ser_ready;
  logic [5:0] g1, g2, g3;
  logic [2:0] msg;
  logic       msg_ready, ser_out, ser_valid, sof, eof;
  logic [5:0] cw_out;

  always #5 clk = ~clk;

  lbc_serial_encoder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .g1_i       (g1),
    .g2_i       (g2),
    .g3_i       (g3),
    .g_load_i   (g_load),
    .msg_i      (msg),
    .msg_valid_i(msg_valid),
    .msg_ready_o(msg_ready),
    .ser_out_o  (ser_out),
    .ser_valid_o(ser_valid),
    .ser_ready_i(ser_ready),
    .sof_o      (sof),
    .eof_o      (eof),
    .cw_out_o   (cw_out)
  );

  int total = 0;
  int bad   = 0;

  // Model: queue of codewords not yet fully sent; head is the frame on the wire.
  logic [5:0] fq[$];
  int         pos;
  logic [5:0] last_cw;
  logic [5:0] gm[3];
  logic       rst_prev;
  logic       chk_on;
  logic       last_acc;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [5:0] encode(input logic [2:0] m);
    logic [5:0] c = 6'b0;
    for (int i = 0; i < 3; i++) if (m[i]) c = c ^ gm[i];
    return c;
  endfunction

  task automatic model_reset();
    fq.delete();
    pos     = 0;
    last_cw = 6'b0;
    gm[0]   = 6'b000001;
    gm[1]   = 6'b000010;
    gm[2]   = 6'b000100;
  endtask

  // One clock: check outputs with inputs settled, then advance the model.
  task automatic cyc();
    logic       er, ev, acc, xf;
    logic [5:0] cw;
    #1;
    er = en & !rst_prev & (fq.size() < 2);
    ev = en & (fq.size() > 0);
    if (chk_on) begin
      chk("msg_ready", msg_ready, er);
      chk("ser_valid", ser_valid, ev);
      if (ev) begin
        chk("ser_out", ser_out, fq[0][5-pos]);
        chk("sof", sof, pos == 0);
        chk("eof", eof, pos == 5);
      end
      chk("cw_out", cw_out, (fq.size() > 0) ? fq[0] : last_cw);
    end
    acc      = msg_valid & er;
    xf       = ev & ser_ready;
    last_acc = acc;
    cw       = encode(msg);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (xf) begin
        pos++;
        if (pos == 6) begin
          last_cw = fq.pop_front();
          pos     = 0;
        end
      end
      if (acc) fq.push_back(cw);
      if (g_load) begin
        gm[0] = g1;
        gm[1] = g2;
        gm[2] = g3;
      end
    end
    rst_prev = rst;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] m);
    int n = 0;
    msg       = m;
    msg_valid = 1'b1;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 50);
    msg_valid = 1'b0;
    if (!last_acc) timeout("send");
  endtask

  task automatic drain();
    int n = 0;
    while (fq.size() > 0 && n < 200) begin
      cyc();
      n++;
    end
    if (fq.size() > 0) timeout("drain");
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(fq.size() > 0 && pos == p) && n < 50) begin
      cyc();
      n++;
    end
    if (!(fq.size() > 0 && pos == p)) timeout("wait_pos");
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; g_load = 1'b0; msg_valid = 1'b0; ser_ready = 1'b1;
    g1 = 6'b0; g2 = 6'b0; g3 = 6'b0; msg = 3'b0;
    rst_prev = 1'b1; chk_on = 1'b0; last_acc = 1'b0;
    model_reset();
    @(negedge clk);
    cyc();
    chk_on = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_sof", sof, 1'b0);

    // Identity G after reset
    send(3'b101);
    chk("t3_cw", cw_out, 6'b000101);
    drain();

    // Loaded G, single frame
    g1 = 6'b110001; g2 = 6'b011010; g3 = 6'b101100; g_load = 1'b1;
    cyc();
    g_load = 1'b0;
    send(3'b011);
    chk("t1_cw", cw_out, 6'b101011);
    chk("t1_valid", ser_valid, 1'b1);
    drain();

    // Back-to-back frames
    send(3'b111);
    send(3'b000);
    send(3'b100);
    drain();

    // ser_ready toggling
    send(3'b011);
    for (int i = 0; i < 16; i++) begin
      ser_ready = i[0];
      cyc();
    end
    ser_ready = 1'b1;
    drain();

    // en freeze after bit 3, with a message offered during the freeze
    send(3'b011);
    wait_pos(3);
    en = 1'b0; msg = 3'b110; msg_valid = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    msg_valid = 1'b0; en = 1'b1;
    drain();

    // G reload in the same cycle as accept uses the old G
    g1 = 6'b111111; g2 = 6'b000000; g3 = 6'b000000; g_load = 1'b1;
    send(3'b001);
    g_load = 1'b0;
    chk("old_g_cw", cw_out, 6'b110001);
    drain();

    // Reset mid-frame with a pending word
    send(3'b011);
    send(3'b110);
    wait_pos(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_valid", ser_valid, 1'b0);
    send(3'b111);
    chk("t6_cw", cw_out, 6'b000111);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      ser_ready = ($urandom_range(0, 3) != 0);
      msg_valid = $urandom_range(0, 1);
      msg       = 3'($urandom);
      g_load    = ($urandom_range(0, 19) == 0);
      g1        = 6'($urandom);
      g2        = 6'($urandom);
      g3        = 6'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; en = 1'b1; ser_ready = 1'b1; msg_valid = 1'b0; g_load = 1'b0;
    cyc();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
